// File: rtl/dpwm_pkg.sv
// Shared constants and FSM encoding for the DPWM duty controller.
package dpwm_pkg;

  localparam int unsigned STEP_DEF     = 50;
  localparam int unsigned TOP_DEF      = 1000;
  localparam int unsigned DUTY_RST_DEF = 500;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned ARITH_W = 11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } dpwm_state_e;

endpackage

// File: rtl/dpwm_step_counter.sv
// Period counter: adds STEP each enabled cycle and wraps from TOP back to 0.
module dpwm_step_counter
  import dpwm_pkg::*;
#(
  parameter int unsigned STEP = STEP_DEF,
  parameter int unsigned TOP  = TOP_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cuenta,
  output logic             wrap
);

  logic [ARITH_W-1:0] sum;

  // The extra bit lets the overshoot past TOP be seen before truncation.
  assign sum  = {1'b0, cuenta} + ARITH_W'(STEP);
  assign wrap = en && (sum > ARITH_W'(TOP));

  always_ff @(posedge CLK) begin
    if (reset || clr) begin
      cuenta <= '0;
    end else if (en) begin
      cuenta <= wrap ? '0 : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/dpwm_duty_ctrl.sv
// DPWM duty controller: button-driven duty setting, run/drain FSM and PWM compare.
module dpwm_duty_ctrl
  import dpwm_pkg::*;
#(
  parameter int unsigned STEP     = STEP_DEF,
  parameter int unsigned TOP      = TOP_DEF,
  parameter int unsigned DUTY_RST = DUTY_RST_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic             btn_up,
  input  logic             btn_dn,
  output logic [CNT_W-1:0] cuenta,
  output logic [CNT_W-1:0] duty,
  output logic             pwm_out,
  output logic             period_start,
  output logic             busy
);

  dpwm_state_e        state_q, state_d;
  logic [CNT_W-1:0]   duty_q, duty_d;
  logic [CNT_W-1:0]   duty_act_q;
  logic               btn_up_q, btn_dn_q;
  logic               up_rise, dn_rise;
  logic [ARITH_W-1:0] duty_sum, duty_dif;
  logic               wrap;

  dpwm_step_counter #(
    .STEP (STEP),
    .TOP  (TOP)
  ) u_counter (
    .CLK    (CLK),
    .reset  (reset),
    .clr    (state_q == StIdle),
    .en     (state_q != StIdle),
    .cuenta (cuenta),
    .wrap   (wrap)
  );

  assign up_rise = btn_up & ~btn_up_q;
  assign dn_rise = btn_dn & ~btn_dn_q;

  always_comb begin
    duty_sum = {1'b0, duty_q} + ARITH_W'(STEP);
    duty_dif = {1'b0, duty_q} - ARITH_W'(STEP);
    duty_d   = duty_q;
    if (up_rise && !dn_rise) begin
      duty_d = (duty_sum > ARITH_W'(TOP)) ? CNT_W'(TOP) : duty_sum[CNT_W-1:0];
    end else if (dn_rise && !up_rise) begin
      // Borrow out of the top bit means the subtraction went below zero.
      duty_d = duty_dif[ARITH_W-1] ? '0 : duty_dif[CNT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      // Dropping en on the last count of a period ends it right there.
      StRun:   if (!en) state_d = wrap ? StIdle : StDrain;
      StDrain: begin
        if (en) begin
          state_d = StRun;
        end else if (wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= StIdle;
      busy         <= 1'b0;
      period_start <= 1'b0;
      duty_q       <= CNT_W'(DUTY_RST);
      duty_act_q   <= CNT_W'(DUTY_RST);
      btn_up_q     <= btn_up;
      btn_dn_q     <= btn_dn;
    end else begin
      state_q      <= state_d;
      busy         <= (state_d != StIdle);
      period_start <= wrap && (state_d != StIdle);
      duty_q       <= duty_d;
      btn_up_q     <= btn_up;
      btn_dn_q     <= btn_dn;
      if (wrap || (state_q == StIdle && state_d == StRun)) begin
        duty_act_q <= duty_q;
      end
    end
  end

  assign duty    = duty_q;
  assign pwm_out = busy && (cuenta < duty_act_q);

endmodule

// File: tb/tb_dpwm_duty_ctrl.sv
// Directed self-checking bench for dpwm_duty_ctrl with default parameters.
module tb_dpwm_duty_ctrl;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [9:0] cuenta;
  logic [9:0] duty;
  logic       pwm_out;
  logic       period_start;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  dpwm_duty_ctrl dut (
    .CLK          (CLK),
    .reset        (reset),
    .en           (en),
    .btn_up       (btn_up),
    .btn_dn       (btn_dn),
    .cuenta       (cuenta),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_tests++;
    if (cuenta !== 10'd0) begin n_fail++; $display("FAIL reset_cuenta: got %0d want 0", cuenta); end
    n_tests++;
    if (duty !== 10'd500) begin n_fail++; $display("FAIL reset_duty: got %0d want 500", duty); end
    n_tests++;
    if ({pwm_out, period_start, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {pwm_out, period_start, busy});
    end
    repeat (3) step();
    n_tests++;
    if (cuenta !== 10'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: cuenta %0d busy %b want 0 0", cuenta, busy);
    end
  endtask

  task automatic test_period();
    int   highs = 0;
    logic exp_pwm;
    en = 1'b1;
    for (int c = 0; c <= 42; c++) begin
      step();
      n_tests++;
      if (cuenta !== 10'((c % 21) * 50)) begin
        n_fail++; $display("FAIL period_cuenta c=%0d: got %0d want %0d", c, cuenta, (c % 21) * 50);
      end
      n_tests++;
      if (period_start !== (c == 21 || c == 42)) begin
        n_fail++; $display("FAIL period_start c=%0d: got %b", c, period_start);
      end
      exp_pwm = ((c % 21) * 50) < 500;
      n_tests++;
      if (pwm_out !== exp_pwm) begin
        n_fail++; $display("FAIL period_pwm c=%0d: got %b want %b", c, pwm_out, exp_pwm);
      end
      if (c < 21 && pwm_out === 1'b1) highs++;
    end
    n_tests++;
    if (highs != 10) begin n_fail++; $display("FAIL period_highs: got %0d want 10", highs); end
  endtask

  task automatic test_duty_update();
    int   highs = 0;
    logic exp_pwm;
    repeat (6) step();
    n_tests++;
    if (cuenta !== 10'd300) begin n_fail++; $display("FAIL upd_pos: got %0d want 300", cuenta); end
    btn_up = 1'b1;
    step();
    btn_up = 1'b0;
    n_tests++;
    if (duty !== 10'd550) begin n_fail++; $display("FAIL upd_duty: got %0d want 550", duty); end
    for (int v = 350; v <= 1000; v += 50) begin
      exp_pwm = v < 500;
      n_tests++;
      if (cuenta !== 10'(v) || pwm_out !== exp_pwm) begin
        n_fail++;
        $display("FAIL upd_old cnt/pwm: got %0d/%b want %0d/%b", cuenta, pwm_out, v, exp_pwm);
      end
      step();
    end
    for (int i = 0; i < 21; i++) begin
      exp_pwm = (i * 50) < 550;
      n_tests++;
      if (cuenta !== 10'(i * 50) || pwm_out !== exp_pwm) begin
        n_fail++;
        $display("FAIL upd_new cnt/pwm: got %0d/%b want %0d/%b", cuenta, pwm_out, i * 50, exp_pwm);
      end
      if (pwm_out === 1'b1) highs++;
      step();
    end
    n_tests++;
    if (highs != 11) begin n_fail++; $display("FAIL upd_highs: got %0d want 11", highs); end
  endtask

  task automatic test_saturation();
    int guard = 0;
    repeat (9) begin btn_up = 1'b1; step(); btn_up = 1'b0; step(); end
    n_tests++;
    if (duty !== 10'd1000) begin n_fail++; $display("FAIL sat_reach: got %0d want 1000", duty); end
    repeat (3) begin
      btn_up = 1'b1; step(); btn_up = 1'b0; step();
      n_tests++;
      if (duty !== 10'd1000) begin n_fail++; $display("FAIL sat_top: got %0d want 1000", duty); end
    end
    for (int k = 1; k <= 25; k++) begin
      btn_dn = 1'b1; step(); btn_dn = 1'b0; step();
      n_tests++;
      if (duty !== 10'((k >= 20) ? 0 : 1000 - 50 * k)) begin
        n_fail++; $display("FAIL sat_dn k=%0d: got %0d", k, duty);
      end
    end
    do begin step(); guard++; end while (period_start !== 1'b1 && guard < 25);
    n_tests++;
    if (period_start !== 1'b1) begin
      n_fail++; $display("FAIL sat_wrap_timeout: got %b want 1", period_start);
    end
    for (int i = 0; i < 21; i++) begin
      n_tests++;
      if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL sat_zero i=%0d: got %b want 0", i, pwm_out); end
      step();
    end
    repeat (10) begin btn_up = 1'b1; step(); btn_up = 1'b0; step(); end
    n_tests++;
    if (duty !== 10'd500) begin n_fail++; $display("FAIL sat_restore: got %0d want 500", duty); end
  endtask

  task automatic test_drain();
    int guard = 0;
    while (cuenta !== 10'd400 && guard < 30) begin step(); guard++; end
    n_tests++;
    if (cuenta !== 10'd400) begin n_fail++; $display("FAIL drain_find: got %0d want 400", cuenta); end
    en = 1'b0;
    step();
    for (int v = 450; v <= 1000; v += 50) begin
      n_tests++;
      if (cuenta !== 10'(v) || busy !== 1'b1) begin
        n_fail++; $display("FAIL drain_run: cnt %0d busy %b want %0d 1", cuenta, busy, v);
      end
      step();
    end
    n_tests++;
    if ({cuenta, busy, period_start} !== {10'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_idle: cnt %0d busy %b ps %b want 0 0 0", cuenta, busy, period_start);
    end
    repeat (3) step();
    en = 1'b1;
    step();
    n_tests++;
    if ({cuenta, busy, period_start} !== {10'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_reentry: cnt %0d busy %b ps %b want 0 1 0", cuenta, busy, period_start);
    end
    repeat (8) step();
    en = 1'b0;
    repeat (6) step();
    n_tests++;
    if (cuenta !== 10'd700 || busy !== 1'b1) begin
      n_fail++; $display("FAIL drain_mid: cnt %0d busy %b want 700 1", cuenta, busy);
    end
    en = 1'b1;
    step();
    n_tests++;
    if (cuenta !== 10'd750) begin n_fail++; $display("FAIL drain_resume: got %0d want 750", cuenta); end
    repeat (6) step();
    n_tests++;
    if ({cuenta, busy, period_start} !== {10'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL drain_nogap: cnt %0d busy %b ps %b want 0 1 1", cuenta, busy, period_start);
    end
  endtask

  task automatic test_buttons();
    int guard = 0;
    en = 1'b0;
    while (busy !== 1'b0 && guard < 25) begin step(); guard++; end
    n_tests++;
    if (busy !== 1'b0 || cuenta !== 10'd0) begin
      n_fail++; $display("FAIL btn_idle: busy %b cnt %0d want 0 0", busy, cuenta);
    end
    btn_up = 1'b1; btn_dn = 1'b1;
    step();
    n_tests++;
    if (duty !== 10'd500) begin n_fail++; $display("FAIL btn_both: got %0d want 500", duty); end
    btn_up = 1'b0; btn_dn = 1'b0;
    step();
    btn_up = 1'b1;
    repeat (10) step();
    n_tests++;
    if (duty !== 10'd550) begin n_fail++; $display("FAIL btn_held: got %0d want 550", duty); end
    btn_up = 1'b0;
    step();
    n_tests++;
    if (duty !== 10'd550) begin n_fail++; $display("FAIL btn_release: got %0d want 550", duty); end
    btn_dn = 1'b1; step(); btn_dn = 1'b0; step();
    n_tests++;
    if (duty !== 10'd500 || cuenta !== 10'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL btn_dn_idle: duty %0d cnt %0d busy %b want 500 0 0", duty, cuenta, busy);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    btn_up = 1'b1; step(); btn_up = 1'b0; step();
    n_tests++;
    if (duty !== 10'd550) begin n_fail++; $display("FAIL rstm_pre: got %0d want 550", duty); end
    en = 1'b1;
    while (cuenta !== 10'd650 && guard < 30) begin step(); guard++; end
    n_tests++;
    if (cuenta !== 10'd650) begin n_fail++; $display("FAIL rstm_find: got %0d want 650", cuenta); end
    reset = 1'b1; btn_up = 1'b1; btn_dn = 1'b1;
    step();
    reset = 1'b0; en = 1'b0;
    n_tests++;
    if ({cuenta, duty, pwm_out, busy, period_start} !== {10'd0, 10'd500, 3'b000}) begin
      n_fail++;
      $display("FAIL rstm_state: cnt %0d duty %0d pwm %b busy %b want 0 500 0 0",
               cuenta, duty, pwm_out, busy);
    end
    repeat (3) step();
    n_tests++;
    if (duty !== 10'd500) begin n_fail++; $display("FAIL rstm_held: got %0d want 500", duty); end
    btn_up = 1'b0; btn_dn = 1'b0;
    step();
    n_tests++;
    if (duty !== 10'd500 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstm_after: duty %0d busy %b want 500 0", duty, busy);
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_duty_update();
    test_saturation();
    test_drain();
    test_buttons();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
